// File: rtl/dispatch_inst_buffer_pkg.sv
// Shared types and default sizing for the instruction buffer between decode and dispatch.
package dispatch_inst_buffer_pkg;

  localparam int EXC_CAUSE_WIDTH = 6;

  localparam int IB_DEPTH     = 8;
  localparam int IB_ENQ_WIDTH = 2;
  localparam int IB_DEQ_WIDTH = 2;

  typedef logic [31:0] bus32_t;

  typedef struct packed {
    bus32_t                                pc;
    bus32_t                                inst;
    logic                                  pre_is_branch;
    logic                                  pre_is_branch_taken;
    bus32_t                                pre_branch_addr;
    logic [5:0]                            is_exception;
    logic [5:0][EXC_CAUSE_WIDTH-1:0]       exception_cause;
  } ib_entry_t;

endpackage

// File: rtl/dispatch_inst_buffer_prefix_count.sv
// Counts the run of consecutive ones in a mask, starting at bit 0.
module ib_prefix_count #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  mask,
  output logic [CW-1:0] cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & mask[i];
      if (run) cnt = CW'(i + 1);
    end
  end

endmodule

// File: rtl/dispatch_inst_buffer.sv
// Circular instruction buffer: up to ENQ_WIDTH decoded instructions in, up to DEQ_WIDTH out,
// oldest first, with single-issue throttling and a one-cycle flush.
module dispatch_inst_buffer
  import dispatch_inst_buffer_pkg::*;
#(
  parameter int DEPTH     = IB_DEPTH,
  parameter int ENQ_WIDTH = IB_ENQ_WIDTH,
  parameter int DEQ_WIDTH = IB_DEQ_WIDTH,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             single_issue,
  input  logic [ENQ_WIDTH-1:0]             enq_valid,
  input  ib_entry_t [ENQ_WIDTH-1:0]        enq_entry,
  output logic                             enq_ready,
  output logic [DEQ_WIDTH-1:0]             deq_valid,
  output ib_entry_t [DEQ_WIDTH-1:0]        deq_entry,
  input  logic [DEQ_WIDTH-1:0]             deq_ready,
  output logic [CNT_W-1:0]                 count
);

  // Handshake: an enq group is taken only when enq_ready is high, and then only
  // the contiguous valid prefix from lane 0; a dequeue lane retires only when it
  // is part of the contiguous valid&ready prefix from lane 0. flush drops both.

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ENQ_CW = $clog2(ENQ_WIDTH + 1);
  localparam int DEQ_CW = $clog2(DEQ_WIDTH + 1);

  ib_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  logic [ENQ_CW-1:0]  enq_pfx;
  logic [ENQ_CW-1:0]  n_enq;
  logic [DEQ_CW-1:0]  n_deq;
  logic [DEQ_WIDTH-1:0] deq_fire_mask;

  assign count     = count_q;
  // Conservative: a dequeue in the same cycle does not free space for enqueue.
  assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);

  ib_prefix_count #(.W(ENQ_WIDTH), .CW(ENQ_CW)) u_enq_pfx (
    .mask (enq_valid),
    .cnt  (enq_pfx)
  );

  assign n_enq = enq_ready ? enq_pfx : '0;

  always_comb begin
    deq_valid = '0;
    deq_entry = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      deq_valid[i] = (CNT_W'(i) < count_q) && !(single_issue && (i > 0));
      if (deq_valid[i]) deq_entry[i] = mem[head_q + PTR_W'(i)];
    end
  end

  assign deq_fire_mask = deq_valid & deq_ready;

  ib_prefix_count #(.W(DEQ_WIDTH), .CW(DEQ_CW)) u_deq_pfx (
    .mask (deq_fire_mask),
    .cnt  (n_deq)
  );

  // Payload storage is deliberately not reset; occupancy alone decides visibility.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (ENQ_CW'(k) < n_enq) mem[tail_q + PTR_W'(k)] <= enq_entry[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(n_deq);
      tail_q  <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (!rst)
    (count_q <= CNT_W'(DEPTH)) && (tail_q == head_q + PTR_W'(count_q)));

endmodule

// File: tb/tb_dispatch_inst_buffer.sv
// Bench for dispatch_inst_buffer: directed corner cases then random traffic,
// checked against a queue-based model of the buffer contents.
module tb_dispatch_inst_buffer;
  import dispatch_inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = $bits(ib_entry_t);

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    single_issue;
  logic [ENQ_W-1:0]        enq_valid;
  ib_entry_t [ENQ_W-1:0]   enq_entry;
  logic                    enq_ready;
  logic [DEQ_W-1:0]        deq_valid;
  ib_entry_t [DEQ_W-1:0]   deq_entry;
  logic [DEQ_W-1:0]        deq_ready;
  logic [CNT_W-1:0]        count;

  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_miss;
  int seq;

  dispatch_inst_buffer #(
    .DEPTH(DEPTH), .ENQ_WIDTH(ENQ_W), .DEQ_WIDTH(DEQ_W), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .single_issue (single_issue),
    .enq_valid    (enq_valid),
    .enq_entry    (enq_entry),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_entry    (deq_entry),
    .deq_ready    (deq_ready),
    .count        (count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lead_ones(input logic [1:0] m);
    if (m[0] && m[1]) return 2;
    if (m[0]) return 1;
    return 0;
  endfunction

  function automatic ib_entry_t make_entry(input int s);
    logic [EW-1:0] b;
    ib_entry_t e;
    for (int j = 0; j < EW; j++) b[j] = 1'($urandom_range(0, 1));
    e = ib_entry_t'(b);
    e.pc = 32'h1c00_0000 + 32'(s * 4);
    return e;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_count"}, EW'(count), EW'(0));
    check({tag, "_deq_valid"}, EW'(deq_valid), EW'(0));
    check({tag, "_enq_ready"}, EW'(enq_ready), EW'(1));
  endtask

  // Driver: one cycle of stimulus, model-checked status, then model update.
  task automatic do_cycle(input logic [1:0] ev, input logic [1:0] dr,
                          input logic si, input logic fl);
    int occ;
    int n;
    logic [1:0] exp_dv;
    ib_entry_t lane_e [ENQ_W];
    @(negedge clk);
    for (int k = 0; k < ENQ_W; k++) begin
      lane_e[k]    = make_entry(seq + k);
      enq_entry[k] = lane_e[k];
    end
    enq_valid    = ev;
    deq_ready    = dr;
    single_issue = si;
    flush        = fl;
    #2;
    occ = exp_q.size();
    for (int i = 0; i < DEQ_W; i++) exp_dv[i] = (i < occ) && !(si && i > 0);
    check("count", EW'(count), EW'(occ));
    check("enq_ready", EW'(enq_ready), EW'((DEPTH - occ) >= ENQ_W));
    check("deq_valid", EW'(deq_valid), EW'(exp_dv));
    #2;
    if (fl) begin
      exp_q.delete();
    end else if ((DEPTH - occ) >= ENQ_W) begin
      n = lead_ones(ev);
      for (int k = 0; k < n; k++) exp_q.push_back(EW'(lane_e[k]));
      seq += n;
    end
  endtask

  // Monitor: every visible lane must show the matching oldest entry; retired lanes pop.
  initial begin
    int  n;
    logic run;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < DEQ_W; i++) begin
          if (deq_valid[i]) begin
            if (i < exp_q.size()) check("deq_entry", EW'(deq_entry[i]), exp_q[i]);
          end else begin
            check("deq_entry_zero", EW'(deq_entry[i]), EW'(0));
          end
          run = run & deq_valid[i] & deq_ready[i];
          if (run) n++;
        end
        if (!flush) begin
          for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; seq = 0;
    rst = 1'b0; flush = 1'b0; single_issue = 1'b0;
    enq_valid = '0; deq_ready = '0; enq_entry = '0;
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;

    // First pair, then non-prefix and single-lane enqueues
    do_cycle(2'b11, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b10, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b01, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b00, 2'b01, 1'b0, 1'b0);
    // Fill to full, extra enqueue ignored, then drain two
    repeat (3) do_cycle(2'b11, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b11, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b00, 2'b11, 1'b0, 1'b0);
    // Wrap with simultaneous enq/deq at DEPTH-ENQ_WIDTH
    repeat (4) do_cycle(2'b11, 2'b11, 1'b0, 1'b0);
    do_cycle(2'b00, 2'b10, 1'b0, 1'b0);
    // Single issue at count 4
    do_cycle(2'b00, 2'b11, 1'b0, 1'b0);
    do_cycle(2'b00, 2'b11, 1'b1, 1'b0);
    // Flush at count 5 with same-cycle enq and deq
    do_cycle(2'b11, 2'b00, 1'b0, 1'b0);
    do_cycle(2'b11, 2'b11, 1'b0, 1'b1);
    do_cycle(2'b00, 2'b00, 1'b0, 1'b0);
    repeat (3) do_cycle(2'b11, 2'b01, 1'b0, 1'b0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    enq_valid = '0; deq_ready = '0; flush = 1'b0; single_issue = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b1;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      do_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end
    repeat (6) do_cycle(2'b00, 2'b11, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
